preg_free_list: RTL and testbench

- Physical-register free list for the rename/dispatch stage.
- Supplies destination physical registers (prd) to renamed instructions each cycle. These are the same prd values that dispatch later marks busy in the busy table.
- Reclaims stale prds at commit, and rolls back allocations during a misprediction walk.
- Circular buffer with separate allocate (head) and free (tail) pointers, each carrying a wrap bit.

---
 rtl/preg_free_list_pkg.sv | 48 ++++
 rtl/preg_free_list_if.sv | 33 +++
 rtl/preg_free_list_ptr_add.sv | 33 +++
 rtl/preg_free_list.sv | 122 ++++++++++++
 tb/tb_preg_free_list.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/preg_free_list_pkg.sv
// Shared types, sizes and index helpers for the physical-register free list.
package preg_free_list_pkg;

  localparam int PREG_SIZE    = 128;
  localparam int ARCH_SIZE    = 32;
  localparam int FETCH_WIDTH  = 4;
  localparam int COMMIT_WIDTH = 4;
  localparam int DEPTH        = PREG_SIZE - ARCH_SIZE;
  localparam int PREG_WIDTH   = $clog2(PREG_SIZE);
  localparam int IDX_W        = $clog2(DEPTH);
  localparam int CNT_W        = $clog2(DEPTH + 1);
  localparam int SLOTS        = (FETCH_WIDTH > COMMIT_WIDTH) ? FETCH_WIDTH : COMMIT_WIDTH;
  localparam int SLOT_W       = $clog2(SLOTS + 1);

  typedef logic [PREG_WIDTH-1:0] preg_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef struct packed {
    logic wrap;
    idx_t idx;
  } ptr_t;

  localparam logic [IDX_W:0] DEPTH_W = (IDX_W + 1)'(DEPTH);

  // Number of set bits in v below position n.
  function automatic logic [SLOT_W-1:0] prefix_count(input logic [SLOTS-1:0] v, input int n);
    logic [SLOT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (i < n && v[i]) cnt = cnt + SLOT_W'(1);
    end
    return cnt;
  endfunction

  // DEPTH is not a power of two, so wrap with compare-and-subtract.
  function automatic idx_t idx_add(input idx_t i, input logic [SLOT_W-1:0] n);
    logic [IDX_W:0] s;
    s = {1'b0, i} + (IDX_W + 1)'(n);
    return (s >= DEPTH_W) ? idx_t'(s - DEPTH_W) : s[IDX_W-1:0];
  endfunction

  function automatic idx_t idx_sub(input idx_t i, input logic [SLOT_W-1:0] n);
    logic [IDX_W:0] s;
    s = {1'b0, i} + DEPTH_W - (IDX_W + 1)'(n);
    return (i >= idx_t'(n)) ? (i - idx_t'(n)) : s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename-side bus of the free list. The err signal exists only with PREG_FREE_LIST_CHECK_EN.
interface preg_free_list_if import preg_free_list_pkg::*; ();
  logic [FETCH_WIDTH-1:0]             alloc_req;
  logic                               alloc_ready;
  logic [FETCH_WIDTH*PREG_WIDTH-1:0]  alloc_prd;
  logic [COMMIT_WIDTH-1:0]            free_en;
  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] free_preg;
  logic                               redirect;
  logic                               walk;
  logic [COMMIT_WIDTH-1:0]            walk_en;
  logic [CNT_W-1:0]                   free_count;
`ifdef PREG_FREE_LIST_CHECK_EN
  logic                               err;
`endif

  // A slot's allocation fires only on a cycle where alloc_req[k] and alloc_ready are both high;
  // otherwise the requester holds. Frees and walks are unconditional (no ready).
  modport master (
    output alloc_req, free_en, free_preg, redirect, walk, walk_en,
    input  alloc_ready, alloc_prd, free_count
`ifdef PREG_FREE_LIST_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  alloc_req, free_en, free_preg, redirect, walk, walk_en,
    output alloc_ready, alloc_prd, free_count
`ifdef PREG_FREE_LIST_CHECK_EN
    , output err
`endif
  );
endinterface

// File: rtl/preg_free_list_ptr_add.sv
// Wrap-bit pointer that moves forward or backward by a small count modulo DEPTH.
module free_list_ptr_add
  import preg_free_list_pkg::*;
(
  input  ptr_t              ptr_in,
  input  logic [SLOT_W-1:0] cnt,
  input  logic              sub,
  output ptr_t              ptr_out
);

  logic [IDX_W:0] sum;

  always_comb begin
    ptr_out = ptr_in;
    sum     = '0;
    if (!sub) begin
      sum = {1'b0, ptr_in.idx} + (IDX_W + 1)'(cnt);
      if (sum >= DEPTH_W) begin
        ptr_out.idx  = idx_t'(sum - DEPTH_W);
        ptr_out.wrap = ~ptr_in.wrap;
      end else begin
        ptr_out.idx = sum[IDX_W-1:0];
      end
    end else if (ptr_in.idx >= idx_t'(cnt)) begin
      ptr_out.idx = ptr_in.idx - idx_t'(cnt);
    end else begin
      sum          = {1'b0, ptr_in.idx} + DEPTH_W - (IDX_W + 1)'(cnt);
      ptr_out.idx  = sum[IDX_W-1:0];
      ptr_out.wrap = ~ptr_in.wrap;
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: circular buffer, head allocates, tail reclaims, walk rolls head back.
// Optional PREG_FREE_LIST_CHECK_EN adds an in-list shadow bitmap and a sticky err output.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  preg_free_list_if.slave  bus
);

  ptr_t               head_q, tail_q, head_adv, head_back, tail_adv, head_d;
  preg_t              mem_q [DEPTH];
  preg_t              grant [FETCH_WIDTH];
  logic [CNT_W-1:0]   count, allocated;
  logic [SLOT_W-1:0]  alloc_num, free_num, walk_num, alloc_take;
  logic [COMMIT_WIDTH-1:0] free_ok;
  logic               ready, fire, walk_ovf;
  logic [CNT_W:0]     free_total;

  // Full is equal indices with differing wrap bits.
  always_comb begin
    if (head_q.wrap != tail_q.wrap)
      count = CNT_W'({1'b0, tail_q.idx} + DEPTH_W - {1'b0, head_q.idx});
    else
      count = CNT_W'(tail_q.idx - head_q.idx);
  end

  assign allocated = CNT_W'(DEPTH) - count;
  assign ready     = (count >= CNT_W'(FETCH_WIDTH)) && !bus.walk && !bus.redirect;
  assign fire      = ready && (|bus.alloc_req);
  assign alloc_num = prefix_count(bus.alloc_req, FETCH_WIDTH);
  assign walk_num  = prefix_count(bus.walk_en, COMMIT_WIDTH);
  assign walk_ovf  = bus.walk && (CNT_W'(walk_num) > allocated);

  always_comb begin
    bus.alloc_prd = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      grant[k] = mem_q[idx_add(head_q.idx, prefix_count(bus.alloc_req, k))];
      bus.alloc_prd[k*PREG_WIDTH +: PREG_WIDTH] = grant[k];
    end
  end

  // x0 is never renamed, so freeing preg 0 is a no-op.
  always_comb begin
    for (int j = 0; j < COMMIT_WIDTH; j++)
      free_ok[j] = bus.free_en[j] && (bus.free_preg[j*PREG_WIDTH +: PREG_WIDTH] != '0);
  end
  assign free_num = prefix_count(free_ok, COMMIT_WIDTH);

  free_list_ptr_add u_head_adv  (.ptr_in(head_q), .cnt(alloc_num), .sub(1'b0), .ptr_out(head_adv));
  free_list_ptr_add u_head_back (.ptr_in(head_q), .cnt(walk_num),  .sub(1'b1), .ptr_out(head_back));
  free_list_ptr_add u_tail_adv  (.ptr_in(tail_q), .cnt(free_num),  .sub(1'b0), .ptr_out(tail_adv));

  always_comb begin
    head_d = head_q;
    if (bus.walk)  head_d = head_back;
    else if (fire) head_d = head_adv;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '{wrap: 1'b0, idx: '0};
      tail_q <= '{wrap: 1'b1, idx: '0};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= preg_t'(ARCH_SIZE + i);
    end else begin
      head_q <= head_d;
      tail_q <= tail_adv;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (free_ok[j])
          mem_q[idx_add(tail_q.idx, prefix_count(free_ok, j))] <=
            bus.free_preg[j*PREG_WIDTH +: PREG_WIDTH];
      end
    end
  end

  assign bus.alloc_ready = ready;
  assign bus.free_count  = count;

  assign alloc_take = fire ? alloc_num : '0;
  assign free_total = {1'b0, count} + (CNT_W + 1)'(free_num) - (CNT_W + 1)'(alloc_take);

  free_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    free_total <= (CNT_W + 1)'(DEPTH));
  walk_overflow_a: assert property (@(posedge clk) disable iff (!rst) !walk_ovf);

`ifdef PREG_FREE_LIST_CHECK_EN
  logic [PREG_SIZE-1:0] in_list_q;
  logic                 err_q, err_now;

  always_comb begin
    err_now = walk_ovf;
    for (int k = 0; k < FETCH_WIDTH; k++)
      if (fire && bus.alloc_req[k] && !in_list_q[grant[k]]) err_now = 1'b1;
    for (int j = 0; j < COMMIT_WIDTH; j++)
      if (free_ok[j] && in_list_q[bus.free_preg[j*PREG_WIDTH +: PREG_WIDTH]]) err_now = 1'b1;
  end

  // Walked entries are the ones just below head; they re-enter the list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_list_q <= {{DEPTH{1'b1}}, {ARCH_SIZE{1'b0}}};
      err_q     <= 1'b0;
    end else begin
      err_q <= err_q | err_now;
      for (int k = 0; k < FETCH_WIDTH; k++)
        if (fire && bus.alloc_req[k]) in_list_q[grant[k]] <= 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (bus.walk && (SLOT_W'(i) < walk_num))
          in_list_q[mem_q[idx_sub(head_q.idx, SLOT_W'(i + 1))]] <= 1'b1;
      for (int j = 0; j < COMMIT_WIDTH; j++)
        if (free_ok[j]) in_list_q[bus.free_preg[j*PREG_WIDTH +: PREG_WIDTH]] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst && err_now) $error("preg_free_list: free-list consistency error");
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Directed table-driven bench for preg_free_list plus hand-written multi-cycle sequences.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  preg_free_list_if bus ();
  preg_free_list dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  fen;
    logic [27:0] fp;
    logic        redir;
    logic        walk;
    logic [3:0]  wen;
    logic        exp_ready;
    int          exp_count;
    logic [27:0] exp_prd;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive at a negedge, sample 2ns later (well before the posedge), then move to next negedge.
  task automatic step(input string name, input logic [3:0] req, input logic [3:0] fen,
                      input logic [27:0] fp, input logic redir, input logic walk,
                      input logic [3:0] wen, input logic exp_ready, input int exp_count,
                      input logic [27:0] exp_prd);
    logic [27:0] prd;
    bus.alloc_req = req;
    bus.free_en   = fen;
    bus.free_preg = fp;
    bus.redirect  = redir;
    bus.walk      = walk;
    bus.walk_en   = wen;
    #2;
    prd = bus.alloc_prd;
    check({name, ".ready"}, int'(bus.alloc_ready), int'(exp_ready));
    check({name, ".count"}, int'(bus.free_count), exp_count);
    if (exp_ready) begin
      for (int k = 0; k < 4; k++)
        if (req[k]) check($sformatf("%s.prd%0d", name, k), int'(prd[k*7 +: 7]), int'(exp_prd[k*7 +: 7]));
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alloc_req = '0;
    bus.free_en   = '0;
    bus.free_preg = '0;
    bus.redirect  = 1'b0;
    bus.walk      = 1'b0;
    bus.walk_en   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0000, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 96, pk(0,0,0,0)};
    vecs[1]  = '{4'b1111, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 96, pk(32,33,34,35)};
    vecs[2]  = '{4'b1010, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 92, pk(0,36,0,37)};
    vecs[3]  = '{4'b0000, 4'b0000, pk(0,0,0,0),   1'b1, 1'b0, 4'b0000, 1'b0, 90, pk(0,0,0,0)};
    vecs[4]  = '{4'b1111, 4'b0000, pk(0,0,0,0),   1'b1, 1'b0, 4'b0000, 1'b0, 90, pk(0,0,0,0)};
    vecs[5]  = '{4'b0001, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 90, pk(38,0,0,0)};
    vecs[6]  = '{4'b0000, 4'b0000, pk(0,0,0,0),   1'b0, 1'b1, 4'b0111, 1'b0, 89, pk(0,0,0,0)};
    vecs[7]  = '{4'b0001, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 92, pk(36,0,0,0)};
    vecs[8]  = '{4'b0000, 4'b0101, pk(5,9,6,0),   1'b0, 1'b0, 4'b0000, 1'b1, 91, pk(0,0,0,0)};
    vecs[9]  = '{4'b0000, 4'b1111, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 93, pk(0,0,0,0)};
    vecs[10] = '{4'b0000, 4'b0001, pk(10,0,0,0),  1'b0, 1'b1, 4'b1000, 1'b0, 93, pk(0,0,0,0)};
    vecs[11] = '{4'b0000, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 95, pk(0,0,0,0)};
    vecs[12] = '{4'b0100, 4'b0000, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 95, pk(0,0,36,0)};

    do_reset();
    for (int i = 0; i < 13; i++)
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].fen, vecs[i].fp, vecs[i].redir,
           vecs[i].walk, vecs[i].wen, vecs[i].exp_ready, vecs[i].exp_count, vecs[i].exp_prd);

    // Drain to count 3, stall, free, then allocate across the DEPTH wrap with a same-cycle free.
    do_reset();
    for (int i = 0; i < 23; i++)
      step($sformatf("drain%0d", i), 4'b1111, 4'b0000, '0, 1'b0, 1'b0, 4'b0000, 1'b1, 96 - 4*i,
           pk(32+4*i, 33+4*i, 34+4*i, 35+4*i));
    step("last1",   4'b0001, 4'b0000, '0,             1'b0, 1'b0, 4'b0000, 1'b1, 4, pk(124,0,0,0));
    step("stall",   4'b1111, 4'b0000, '0,             1'b0, 1'b0, 4'b0000, 1'b0, 3, '0);
    step("free56",  4'b0000, 4'b0011, pk(5,6,0,0),    1'b0, 1'b0, 4'b0000, 1'b0, 3, '0);
    step("wrap",    4'b1111, 4'b0011, pk(7,8,0,0),    1'b0, 1'b0, 4'b0000, 1'b1, 5, pk(125,126,127,5));
    step("free3",   4'b0000, 4'b0111, pk(9,10,11,0),  1'b0, 1'b0, 4'b0000, 1'b0, 3, '0);
    step("postwrap",4'b1111, 4'b0000, '0,             1'b0, 1'b0, 4'b0000, 1'b1, 6, pk(6,7,8,9));
    step("tail2",   4'b0000, 4'b0000, '0,             1'b0, 1'b0, 4'b0000, 1'b0, 2, '0);

    // Allocate 4, walk 3 back, then the next single allocation reuses 33.
    do_reset();
    step("w_alloc", 4'b1111, 4'b0000, '0, 1'b0, 1'b0, 4'b0000, 1'b1, 96, pk(32,33,34,35));
    step("w_walk",  4'b0000, 4'b0000, '0, 1'b0, 1'b1, 4'b0111, 1'b0, 92, '0);
    step("w_after", 4'b0001, 4'b0000, '0, 1'b0, 1'b0, 4'b0000, 1'b1, 95, pk(33,0,0,0));

    // Asynchronous reset in the middle of a cycle restores the full list at once.
    idle_inputs();
    bus.alloc_req = 4'b1111;
    #2 rst = 1'b0;
    #1;
    check("arst.count", int'(bus.free_count), 96);
    check("arst.ready", int'(bus.alloc_ready), 1);
    check("arst.prd0",  int'(bus.alloc_prd[6:0]), 32);
    @(negedge clk);
    rst = 1'b1;
    step("arst.next", 4'b0001, 4'b0000, '0, 1'b0, 1'b0, 4'b0000, 1'b1, 96, pk(32,0,0,0));

`ifdef PREG_FREE_LIST_CHECK_EN
    do_reset();
    #1 check("err.reset", int'(bus.err), 0);
    step("e_alloc", 4'b1111, 4'b0000, '0,            1'b0, 1'b0, 4'b0000, 1'b1, 96, pk(32,33,34,35));
    step("e_zero",  4'b0000, 4'b0001, pk(0,0,0,0),   1'b0, 1'b0, 4'b0000, 1'b1, 92, '0);
    #1 check("err.zero", int'(bus.err), 0);
    step("e_dbl",   4'b0000, 4'b0001, pk(40,0,0,0),  1'b0, 1'b0, 4'b0000, 1'b1, 92, '0);
    idle_inputs();
    #1 check("err.set", int'(bus.err), 1);
    repeat (2) @(negedge clk);
    #1 check("err.sticky", int'(bus.err), 1);
    do_reset();
    #1 check("err.clear", int'(bus.err), 0);
`endif

    idle_inputs();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
